// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    // Double-dabble digit correction: a digit above the threshold gets the addend
    localparam logic [DIGIT_W-1:0] ADJ_THRESHOLD = 4'd4;
    localparam logic [DIGIT_W-1:0] ADJ_ADDEND    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's pre-shift correction: add 3 when the digit exceeds 4.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_adj_c
);

    always_comb begin
        digit_adj_c = digit_in;
        if (digit_in > ADJ_THRESHOLD) begin
            digit_adj_c = digit_in + ADJ_ADDEND;
        end
    end

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter: one bit per cycle, valid/ready on both sides,
// sticky overflow when the operand needs more than DIGITS decimal digits.
module bin2bcd_iter
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                      out_ovf
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned DP_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [DP_W-1:0]    dp_q, dp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   adj_bcd_c;

    // Per-digit correction of the BCD half of the datapath register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in    (dp_q[WIDTH + DIGIT_W*g +: DIGIT_W]),
            .digit_adj_c (adj_bcd_c[DIGIT_W*g +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dp_q    <= dp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dp_d    = dp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dp_d    = {BCD_W'(0), in_data};
                    cnt_d   = CNT_W'(WIDTH);
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The corrected top digit's MSB leaves the register: that is the overflow
                dp_d  = {adj_bcd_c[BCD_W-2:0], dp_q[WIDTH-1:0], 1'b0};
                ovf_d = ovf_q | adj_bcd_c[BCD_W-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = dp_q[DP_W-1 -: BCD_W];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Scoreboard bench: 16/5 and 16/4 converters driven in lockstep with directed vectors,
// plus an 8/3 converter swept 0..255 with random handshake gaps.
module tb_bin2bcd_iter;

    typedef struct packed {
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [19:0] out_bcd_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [15:0] out_bcd_b;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [7:0]  c_in_data;
    logic [11:0] c_out_bcd;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   checks = 0;
    int   errors = 0;
    bit   sweep_on = 1'b0;

    bin2bcd_iter #(.WIDTH(16), .DIGITS(5)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_bcd(out_bcd_a), .out_ovf(out_ovf_a)
    );

    bin2bcd_iter #(.WIDTH(16), .DIGITS(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_bcd(out_bcd_b), .out_ovf(out_ovf_b)
    );

    bin2bcd_iter #(.WIDTH(8), .DIGITS(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bcd(c_out_bcd), .out_ovf(c_out_ovf)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: decimal digits by division, overflow when a quotient remains
    function automatic exp_t ref_bcd(input int unsigned v, input int unsigned digits);
        exp_t        e;
        int unsigned tmp;
        e.bcd = '0;
        tmp   = v;
        for (int i = 0; i < int'(digits); i++) begin
            e.bcd[4*i +: 4] = 4'(tmp % 10);
            tmp = tmp / 10;
        end
        e.ovf = (tmp != 0);
        return e;
    endfunction

    // Monitors: a handshake seen on the falling edge completes on the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid_a && out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_output: got bcd 0x%0h with no result pending", out_bcd_a);
            end else begin
                e = qa.pop_front();
                chk("a_bcd", 64'(out_bcd_a), 64'(e.bcd));
                chk("a_ovf", 64'(out_ovf_a), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid_b && out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_output: got bcd 0x%0h with no result pending", out_bcd_b);
            end else begin
                e = qb.pop_front();
                chk("b_bcd", 64'(out_bcd_b), 64'(e.bcd));
                chk("b_ovf", 64'(out_ovf_b), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected_output: got bcd 0x%0h with no result pending", c_out_bcd);
            end else begin
                e = qc.pop_front();
                chk("c_bcd", 64'(c_out_bcd), 64'(e.bcd));
                chk("c_ovf", 64'(c_out_ovf), 64'(e.ovf));
            end
        end
    end

    // Random consumer backpressure for the sweep instance
    initial begin
        c_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c_out_ready = sweep_on ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    task automatic send_ab(input logic [15:0] v, input logic [19:0] ea, input logic oa,
                           input logic [15:0] eb, input logic ob, input bit push);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready_a && n < 200);
        chk("a_ready_at_accept", 64'(in_ready_a), 64'd1);
        chk("b_ready_at_accept", 64'(in_ready_b), 64'd1);
        @(posedge clk);
        if (push) begin
            qa.push_back(exp_t'{bcd: ea, ovf: oa});
            qb.push_back(exp_t'{bcd: {4'h0, eb}, ovf: ob});
        end
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic send_c(input logic [7:0] v);
        int n;
        n          = 0;
        c_in_valid = 1'b1;
        c_in_data  = v;
        do begin
            @(negedge clk);
            n++;
        end while (!c_in_ready && n < 200);
        chk("c_ready_at_accept", 64'(c_in_ready), 64'd1);
        @(posedge clk);
        qc.push_back(ref_bcd(int'(v), 3));
        #1;
        c_in_valid = 1'b0;
        c_in_data  = 8'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    endtask

    logic [15:0] dir_in [8] = '{16'd65535, 16'd9999, 16'd12345, 16'd1234,
                                16'd10000, 16'd1,    16'd255,   16'd4096};
    logic [19:0] dir_a  [8] = '{20'h65535, 20'h09999, 20'h12345, 20'h01234,
                                20'h10000, 20'h00001, 20'h00255, 20'h04096};
    logic [15:0] dir_b  [8] = '{16'h5535, 16'h9999, 16'h2345, 16'h1234,
                                16'h0000, 16'h0001, 16'h0255, 16'h4096};
    logic        dir_bo [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int edges;
        int seen;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        c_in_valid = 1'b0;
        c_in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_bcd", 64'(out_bcd_a), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf_a), 64'd0);
        chk("rst_c_in_ready", 64'(c_in_ready), 64'd1);
        rst = 1'b0;

        // Zero operand; edges counted with the acceptance edge as the first
        out_ready = 1'b1;
        send_ab(16'd0, 20'h00000, 1'b0, 16'h0000, 1'b0, 1'b1);
        edges = 1;
        while (!out_valid_a && edges < 100) begin
            chk("shift_in_ready_low", 64'(in_ready_a), 64'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency_edges", 64'(edges), 64'd17);
        drain("drain_zero");

        // Back-to-back directed operands on both digit counts
        for (int i = 0; i < 8; i++) begin
            send_ab(dir_in[i], dir_a[i], 1'b0, dir_b[i], dir_bo[i], 1'b1);
        end
        drain("drain_directed");

        // Input activity while busy must not disturb the conversion
        send_ab(16'd9999, 20'h09999, 1'b0, 16'h9999, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'd1111;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("busy_in_ready_low", 64'(in_ready_a), 64'd0);
        end
        in_valid = 1'b0;
        drain("drain_ignore");

        // Backpressure: result held for 5 cycles, released on first out_ready
        out_ready = 1'b0;
        send_ab(16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1, 1'b1);
        edges = 0;
        while (!out_valid_a && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("bp_valid_seen", 64'(out_valid_a), 64'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_bcd_stable", 64'(out_bcd_a), 64'h65535);
            chk("bp_b_bcd_stable", 64'(out_bcd_b), 64'h5535);
            chk("bp_in_ready_low", 64'(in_ready_a), 64'd0);
            chk("bp_valid_held", 64'(out_valid_a), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(out_valid_a), 64'd0);
        chk("bp_release_ready", 64'(in_ready_a), 64'd1);
        drain("drain_bp");

        // Reset on the 7th shift cycle aborts the conversion
        send_ab(16'd4321, 20'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_shift_busy", 64'(in_ready_a), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready_a), 64'd1);
        chk("abort_out_valid", 64'(out_valid_a), 64'd0);
        chk("abort_out_bcd", 64'(out_bcd_a), 64'd0);
        chk("abort_out_ovf", 64'(out_ovf_a), 64'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid_a || out_valid_b) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        send_ab(16'd1234, 20'h01234, 1'b0, 16'h1234, 1'b0, 1'b1);
        drain("drain_after_abort");

        // Exhaustive 8-bit sweep against the reference model
        sweep_on = 1'b1;
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_c(8'(v));
        end
        drain("drain_sweep");
        sweep_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bin2bcd_iter.md
BIN2BCD_ITER -- requirements
Module: bin2bcd_iter

Interface
REQ-001 Parameter WIDTH, default 16, binary input width; legal range 4..64.
REQ-002 Parameter DIGITS, default 5, number of BCD output digits; legal range 1..20.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  in_data holds a value to convert.
REQ-006 in_ready  output  1  block can accept a value this cycle.
REQ-007 in_data  input  WIDTH  unsigned binary operand.
REQ-008 out_valid  output  1  out_bcd/out_ovf hold a finished result.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out_bcd  output  4*DIGITS  packed BCD result; digit 0 (units) at bits [3:0].
REQ-011 out_ovf  output  1  operand not representable in DIGITS decimal digits.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Input handshake (in_valid & in_ready at an edge) SHALL load in_data into a shift register, clear the BCD register and overflow flag, load the cycle counter with WIDTH, and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to every BCD digit > 4, then shift {bcd, bin} left by one bit.
REQ-016 The bit shifted out of the top BCD digit SHALL set the sticky overflow flag; the flag SHALL never clear before the next acceptance.
REQ-017 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE, so out_valid rises WIDTH+1 edges after the acceptance edge.
REQ-018 In DONE, out_bcd and out_ovf SHALL stay stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-019 A new operand SHALL NOT be accepted on the same edge as output handshake; minimum issue interval is WIDTH+2 cycles.
REQ-020 If out_ovf=1, out_bcd SHALL equal the operand modulo 10^DIGITS.
REQ-021 in_valid, in_data changes outside IDLE SHALL be ignored.
REQ-022 The counter SHALL be sized ceil(log2(WIDTH+1)) bits; no wrap may occur for any legal WIDTH.

Reset
REQ-023 While rst=1 the FSM SHALL go to IDLE on the next edge; in_ready=1, out_valid=0, out_bcd=0, out_ovf=0 after that edge.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the conversion with no output handshake; the pending result is discarded.
REQ-025 rst SHALL take priority over all handshakes on the same edge.

Structure
REQ-026 Package bin2bcd_pkg SHALL hold the FSM state enum and the digit-adjust constant (threshold 4, addend 3).
REQ-027 One sub-module, bcd_digit_adj (4-bit in, 4-bit out, combinational add-3-if->4), SHALL be instantiated DIGITS times via generate.
REQ-028 The datapath register SHALL be 4*DIGITS+WIDTH bits wide; no other storage besides FSM state, counter and overflow flag.

Verification
REQ-029 WIDTH=16, DIGITS=5: in_data=0 -> out_bcd=0x00000, out_ovf=0, out_valid rises 17 edges after accept.
REQ-030 WIDTH=16, DIGITS=5: in_data=65535 -> out_bcd=0x65535, out_ovf=0.
REQ-031 WIDTH=16, DIGITS=4: in_data=9999 -> 0x9999, ovf=0; in_data=12345 -> 0x2345, ovf=1.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_bcd constant, in_ready=0 throughout; result released on first out_ready=1.
REQ-033 Reset mid-SHIFT (cycle 7 of 16) -> next edge IDLE, out_valid never rises, next operand 1234 converts to 0x01234.
REQ-034 Random sweep, WIDTH=8/DIGITS=3 exhaustive 0..255 against a reference model, with random in_valid/out_ready gaps.
